spi_cmd_ctrl: RTL

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

---
 rtl/spi_cmd_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_ctrl.sv
// SPI command front end: decodes a command byte, then streams register writes or
// prefetched register reads through an external SPI slave shifter and register bank.
module spi_cmd_ctrl #(
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter int unsigned DEPTH       = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       active
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrite,
    StFetch,
    StRead
  } state_e;

  state_e     state_q, state_d;
  logic       cs_meta_q, cs_s_q, cs_prev_q;
  logic [1:0] sync_vld_q, sync_vld_d;
  logic       armed_q, armed_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_load_q, tx_load_d;
  logic       rd_load_q, rd_load_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       active_q, active_d;

  logic       cs_fall, cs_rise, rx_ok;
  logic [6:0] cmd_addr, addr_inc;

  // Read data is forwarded straight from the bank in the cycle after reg_re so the
  // read path meets the two-cycle rx_valid-to-tx_load latency.
  assign tx_data   = rd_load_q ? reg_rdata : tx_data_q;
  assign tx_load   = tx_load_q | rd_load_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign active    = active_q;

  always_comb begin
    // A falling edge only counts once cs_s has been seen high for real after reset,
    // so a chip select held low across reset does not reopen a transaction.
    cs_fall  = cs_prev_q & ~cs_s_q & armed_q;
    cs_rise  = ~cs_prev_q & cs_s_q;
    rx_ok    = rx_valid & ~cs_s_q;
    cmd_addr = 7'(32'(rx_data[6:0]) % DEPTH);
    addr_inc = (32'(addr_q) == DEPTH - 1) ? 7'd0 : addr_q + 7'd1;

    sync_vld_d  = {sync_vld_q[0], 1'b1};
    armed_d     = armed_q | (sync_vld_q[1] & cs_s_q);
    state_d     = state_q;
    addr_d      = addr_q;
    tx_data_d   = tx_data;
    tx_load_d   = 1'b0;
    rd_load_d   = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;

    if (cs_rise) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d   = StCmd;
            tx_data_d = STATUS_BYTE;
            tx_load_d = 1'b1;
          end
        end
        StCmd: begin
          if (rx_ok) begin
            addr_d = cmd_addr;
            if (rx_data[7]) begin
              state_d    = StFetch;
              reg_re_d   = 1'b1;
              reg_addr_d = cmd_addr;
            end else begin
              state_d = StWrite;
            end
          end
        end
        StWrite: begin
          if (rx_ok) begin
            reg_we_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = rx_data;
            addr_d      = addr_inc;
          end
        end
        StFetch: begin
          state_d   = StRead;
          rd_load_d = 1'b1;
        end
        StRead: begin
          // The master's dummy byte is dropped; it only paces the next prefetch.
          if (rx_ok) begin
            state_d    = StFetch;
            addr_d     = addr_inc;
            reg_re_d   = 1'b1;
            reg_addr_d = addr_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    active_d = ~cs_s_q & (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
      cs_prev_q   <= 1'b1;
      sync_vld_q  <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= StIdle;
      addr_q      <= 7'd0;
      tx_data_q   <= 8'h00;
      tx_load_q   <= 1'b0;
      rd_load_q   <= 1'b0;
      reg_addr_q  <= 7'd0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      cs_meta_q   <= cs;
      cs_s_q      <= cs_meta_q;
      cs_prev_q   <= cs_s_q;
      sync_vld_q  <= sync_vld_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      rd_load_q   <= rd_load_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      active_q    <= active_d;
    end
  end

endmodule
